store_queue_unit: RTL and testbench

// - Parametrised store execution unit for the OOO OTTER. Accepts ready stores from the store reservation station.
// - Computes the effective address and buffers stores in a DEPTH-entry in-order queue.
// - Drains the queue to data-memory port 2 over a request/response handshake, retrying on NACK.
// - Reports each retired store's tag to the common data bus.

---
 rtl/otter_pkg.sv | 37 +++
 rtl/sq_fifo.sv | 82 ++++++++
 rtl/store_queue_unit.sv | 149 ++++++++++++++
 tb/tb_store_queue_unit.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared OTTER types for the store path: RS tag type, memory size encodings,
// store-queue entry layout and drain FSM states.
package otter_pkg;

    localparam int OTTER_XLEN = 32;
    localparam int TAG_W      = 4;

    typedef logic [TAG_W-1:0] RS_tag_type;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        SQ_IDLE,
        SQ_REQ,
        SQ_BACKOFF
    } sq_state_e;

    typedef struct packed {
        logic [OTTER_XLEN-1:0] addr;
        logic [OTTER_XLEN-1:0] data;
        logic [2:0]            mem_type;  // [2]=sign, [1:0]=size
        RS_tag_type            tag;
        logic                  bad;       // misaligned, dropped at the head without a request
    } sq_entry_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sq_fifo.sv
// DEPTH-entry circular buffer of store-queue entries with push, pop, count and a
// flush that optionally keeps the in-flight head entry.
module sq_fifo
    import otter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         push_i,
    input  sq_entry_t                    push_data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  logic                         keep_head_i,
    output sq_entry_t                    head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    sq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && (cnt_q != CNT_W'(DEPTH)) && !flush_i;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (flush_i) begin
            if (keep_head_i && !do_pop && (cnt_q != '0)) begin
                wr_ptr_d = rd_ptr_q + PTR_W'(1);
                cnt_d    = CNT_W'(1);
            end else begin
                wr_ptr_d = rd_ptr_d;
                cnt_d    = '0;
            end
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: storage is not reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/store_queue_unit.sv
// Store execution unit: effective-address adder, in-order store queue and a drain FSM
// to data-memory port 2 with NACK retry. Optional misalign check via STORE_ALIGN_CHK_EN.
module store_queue_unit
    import otter_pkg::*;
#(
    parameter int XLEN      = OTTER_XLEN,
    parameter int DEPTH     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            ISSUE_VALID,
    input  logic [XLEN-1:0] V1,
    input  logic [XLEN-1:0] V2,
    input  logic [XLEN-1:0] V3,
    input  logic            V1_valid,
    input  logic            V2_valid,
    input  logic            V3_valid,
    input  RS_tag_type      rd_tag,
    input  logic [2:0]      mem_type,
    input  logic            FLUSH,
    output logic            ISSUE_READY,
    output logic            MEM_WRITE,
    output logic [XLEN-1:0] MEM_ADDR2,
    output logic [XLEN-1:0] MEM_WRITE_DATA,
    output logic            MEM_SIGN,
    output logic [1:0]      MEM_SIZE,
    input  logic            mem_resp_valid,
    input  logic            mem_resp,
    output logic            done,
    output RS_tag_type      done_tag,
    output logic            err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int RW    = $clog2(MAX_RETRY + 1);

    sq_state_e        state_q, state_d;
    sq_entry_t        enq_entry, head;
    logic [XLEN-1:0]  eff_addr;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;
    logic             issue_fire, pop, more;
    logic             ack, nack, give_up, drop_bad;
    logic [RW-1:0]    retry_q, retry_d;
    logic             done_q, done_d, err_q, err_d;
    RS_tag_type       done_tag_q;

    assign eff_addr   = V1 + V2;
    assign issue_fire = ISSUE_VALID && ISSUE_READY && V1_valid && V2_valid && V3_valid;

    always_comb begin
        enq_entry.addr     = eff_addr;
        enq_entry.data     = V3;
        enq_entry.mem_type = mem_type;
        enq_entry.tag      = rd_tag;
`ifdef STORE_ALIGN_CHK_EN
        enq_entry.bad      = is_misaligned(mem_type[1:0], eff_addr[1:0]);
`else
        enq_entry.bad      = 1'b0;
`endif
    end

    // The head stays queued while in REQ/BACKOFF, so a flush keeps it and only squashes the rest.
    sq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (CLK),
        .rst_n_i     (RST_N),
        .push_i      (issue_fire),
        .push_data_i (enq_entry),
        .pop_i       (pop),
        .flush_i     (FLUSH),
        .keep_head_i (state_q != SQ_IDLE),
        .head_o      (head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign ISSUE_READY = !fifo_full;
    assign more        = fifo_count > CNT_W'(1);
    assign drop_bad    = (state_q == SQ_REQ) && head.bad;
    assign ack         = (state_q == SQ_REQ) && !head.bad && mem_resp_valid && mem_resp;
    assign nack        = (state_q == SQ_REQ) && !head.bad && mem_resp_valid && !mem_resp;
    assign give_up     = nack && (retry_q == RW'(MAX_RETRY));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= SQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SQ_IDLE: begin
                if (!fifo_empty && !FLUSH) state_d = SQ_REQ;
            end
            SQ_REQ: begin
                if (ack || give_up || drop_bad) begin
                    state_d = (more && !FLUSH) ? SQ_REQ : SQ_IDLE;
                end else if (nack) begin
                    state_d = SQ_BACKOFF;
                end
            end
            SQ_BACKOFF: state_d = SQ_REQ;
            default:    state_d = SQ_IDLE;
        endcase
    end

    always_comb begin
        MEM_WRITE = (state_q == SQ_REQ) && !head.bad;
        pop       = ack || give_up || drop_bad;
        done_d    = ack;
        err_d     = give_up || drop_bad;
        retry_d   = retry_q;
        if (pop) begin
            retry_d = '0;
        end else if (nack) begin
            retry_d = retry_q + RW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            retry_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            done_tag_q <= '0;
        end else begin
            retry_q <= retry_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (ack) begin
                done_tag_q <= head.tag;
            end
        end
    end

    assign MEM_ADDR2      = head.addr;
    assign MEM_WRITE_DATA = head.data;
    assign MEM_SIGN       = head.mem_type[2];
    assign MEM_SIZE       = head.mem_type[1:0];
    assign done           = done_q;
    assign done_tag       = done_tag_q;
    assign err            = err_q;

endmodule

// File: tb/tb_store_queue_unit.sv
// Self-checking bench for store_queue_unit: directed scenarios followed by a random
// issue/response phase scored against a queue-based reference model.
module tb_store_queue_unit;

    localparam int DEPTH     = 4;
    localparam int MAX_RETRY = 3;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        ISSUE_VALID;
    logic [31:0] V1, V2, V3;
    logic        V1_valid, V2_valid, V3_valid;
    logic [3:0]  rd_tag;
    logic [2:0]  mem_type;
    logic        FLUSH;
    logic        ISSUE_READY;
    logic        MEM_WRITE;
    logic [31:0] MEM_ADDR2;
    logic [31:0] MEM_WRITE_DATA;
    logic        MEM_SIGN;
    logic [1:0]  MEM_SIZE;
    logic        mem_resp_valid;
    logic        mem_resp;
    logic        done;
    logic [3:0]  done_tag;
    logic        err;

    int errors = 0;
    int checks = 0;

    store_queue_unit #(.XLEN(32), .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .ISSUE_VALID    (ISSUE_VALID),
        .V1             (V1),
        .V2             (V2),
        .V3             (V3),
        .V1_valid       (V1_valid),
        .V2_valid       (V2_valid),
        .V3_valid       (V3_valid),
        .rd_tag         (rd_tag),
        .mem_type       (mem_type),
        .FLUSH          (FLUSH),
        .ISSUE_READY    (ISSUE_READY),
        .MEM_WRITE      (MEM_WRITE),
        .MEM_ADDR2      (MEM_ADDR2),
        .MEM_WRITE_DATA (MEM_WRITE_DATA),
        .MEM_SIGN       (MEM_SIGN),
        .MEM_SIZE       (MEM_SIZE),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp       (mem_resp),
        .done           (done),
        .done_tag       (done_tag),
        .err            (err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  ty;
        logic [3:0]  tag;
    } st_t;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic drive_issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d,
                               input logic [2:0] ty, input logic [3:0] tg);
        ISSUE_VALID = 1'b1;
        V1 = a; V2 = b; V3 = d;
        V1_valid = 1'b1; V2_valid = 1'b1; V3_valid = 1'b1;
        mem_type = ty;
        rd_tag = tg;
    endtask

    task automatic drive_idle();
        ISSUE_VALID = 1'b0;
        V1_valid = 1'b0; V2_valid = 1'b0; V3_valid = 1'b0;
    endtask

    task automatic wait_mw(output bit found);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (MEM_WRITE) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic respond(input logic ok);
        mem_resp_valid = 1'b1;
        mem_resp = ok;
        tick();
        mem_resp_valid = 1'b0;
        mem_resp = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          found, seen_mw, seen_err;
        int          err_cnt;
        logic [3:0]  got [$];
        logic [3:0]  exp_tags [5];
        st_t         mq [$];
        st_t         h;
        logic        exp_done, exp_err, exp_backoff;
        logic        exp_done_n, exp_err_n, exp_backoff_n;
        logic [3:0]  exp_tag, exp_tag_n;
        int          nack_cnt, stall;
        logic        will_enq;
        logic [1:0]  sz;
        logic [31:0] addr, mask;

        exp_tags = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6};
        RST_N = 1'b0; FLUSH = 1'b0;
        V1 = '0; V2 = '0; V3 = '0; rd_tag = '0; mem_type = '0;
        mem_resp_valid = 1'b0; mem_resp = 1'b0;
        drive_idle();

        // Reset values
        tick(); tick();
        check("rst_mem_write", MEM_WRITE, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_done_tag", done_tag, 0);
        check("rst_ready", ISSUE_READY, 1);
        RST_N = 1'b1;
        tick();

        // Single store, t+2 request latency, done next cycle after ACK
        drive_issue(32'h1000, 32'h24, 32'hDEADBEEF, 3'b010, 4'd5);
        tick();
        drive_idle();
        check("single_t1_mw", MEM_WRITE, 0);
        tick();
        check("single_t2_mw", MEM_WRITE, 1);
        check("single_addr", MEM_ADDR2, 32'h1024);
        check("single_data", MEM_WRITE_DATA, 32'hDEADBEEF);
        check("single_size", MEM_SIZE, 2);
        respond(1'b1);
        check("single_done", done, 1);
        check("single_tag", done_tag, 5);
        check("single_idle", MEM_WRITE, 0);
        tick();
        check("single_done_pulse", done, 0);

        // Four back-to-back issues with memory silent; fifth held until space frees
        for (int i = 1; i <= 4; i++) begin
            check("b2b_ready", ISSUE_READY, 1);
            drive_issue(32'h2000, 32'(i * 4), 32'hA0000000 + 32'(i), 3'b010, 4'(i));
            tick();
        end
        drive_idle();
        check("b2b_full", ISSUE_READY, 0);
        drive_issue(32'h2000, 32'h40, 32'hA5, 3'b010, 4'd6);
        tick();
        check("b2b_held", ISSUE_READY, 0);
        for (int c = 0; c < 60 && got.size() < 5; c++) begin
            logic enq_now;
            if (done) got.push_back(done_tag);
            enq_now = ISSUE_VALID && ISSUE_READY;
            mem_resp_valid = MEM_WRITE;
            mem_resp = 1'b1;
            tick();
            if (enq_now) drive_idle();
        end
        mem_resp_valid = 1'b0; mem_resp = 1'b0;
        drive_idle();
        check("b2b_count", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            check("b2b_order", got[i], exp_tags[i]);
        end
        tick(); tick();

        // NACK twice then ACK: one-cycle drop, stable request, single done
        drive_issue(32'h3000, 32'h8, 32'h12345678, 3'b101, 4'd7);
        tick();
        drive_idle();
        wait_mw(found);
        check("nack_mw_seen", found, 1);
        for (int n = 0; n < 2; n++) begin
            respond(1'b0);
            check("nack_backoff", MEM_WRITE, 0);
            tick();
            check("nack_retry_mw", MEM_WRITE, 1);
            check("nack_addr", MEM_ADDR2, 32'h3008);
            check("nack_data", MEM_WRITE_DATA, 32'h12345678);
            check("nack_sign", MEM_SIGN, 1);
            check("nack_size", MEM_SIZE, 1);
        end
        respond(1'b1);
        check("nack_done", done, 1);
        check("nack_tag", done_tag, 7);
        tick();
        check("nack_single_done", done, 0);

        // Four NACKs exhaust the retry budget; next store proceeds
        drive_issue(32'h4000, 32'h0, 32'h88, 3'b010, 4'd8);
        tick();
        drive_issue(32'h4100, 32'h0, 32'h99, 3'b010, 4'd9);
        tick();
        drive_idle();
        check("drop_mw", MEM_WRITE, 1);
        check("drop_addr", MEM_ADDR2, 32'h4000);
        for (int n = 1; n <= 4; n++) begin
            respond(1'b0);
            if (n < 4) begin
                check("drop_backoff", MEM_WRITE, 0);
                check("drop_no_err", err, 0);
                tick();
                check("drop_retry_addr", MEM_ADDR2, 32'h4000);
            end
        end
        check("drop_err", err, 1);
        check("drop_no_done", done, 0);
        check("drop_next_mw", MEM_WRITE, 1);
        check("drop_next_addr", MEM_ADDR2, 32'h4100);
        respond(1'b1);
        check("drop_err_pulse", err, 0);
        check("drop_next_done", done, 1);
        check("drop_next_tag", done_tag, 9);
        tick();

        // FLUSH with three entries, head in REQ; issue in the flush cycle is discarded
        drive_issue(32'h5000, 32'h0, 32'h10, 3'b010, 4'd10);
        tick();
        drive_issue(32'h5100, 32'h0, 32'h11, 3'b010, 4'd11);
        tick();
        drive_issue(32'h5200, 32'h0, 32'h12, 3'b010, 4'd12);
        tick();
        check("flush_head_mw", MEM_WRITE, 1);
        check("flush_head_addr", MEM_ADDR2, 32'h5000);
        drive_issue(32'h5400, 32'h0, 32'h14, 3'b010, 4'd14);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        drive_idle();
        check("flush_inflight", MEM_WRITE, 1);
        check("flush_inflight_addr", MEM_ADDR2, 32'h5000);
        respond(1'b1);
        check("flush_done", done, 1);
        check("flush_tag", done_tag, 10);
        seen_mw = 1'b0;
        for (int c = 0; c < 8; c++) begin
            seen_mw |= MEM_WRITE;
            tick();
        end
        check("flush_squashed", seen_mw, 0);
        check("flush_ready", ISSUE_READY, 1);
        drive_issue(32'h5300, 32'h0, 32'h13, 3'b010, 4'd13);
        tick();
        drive_idle();
        wait_mw(found);
        check("flush_after_mw", found, 1);
        check("flush_after_addr", MEM_ADDR2, 32'h5300);
        respond(1'b1);
        check("flush_after_tag", done_tag, 13);
        tick();

        // Misaligned word store
        drive_issue(32'h1000, 32'h2, 32'hCAFE, 3'b010, 4'd3);
        tick();
        drive_idle();
`ifdef STORE_ALIGN_CHK_EN
        seen_mw = 1'b0; err_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            seen_mw |= MEM_WRITE;
            if (err) err_cnt++;
            tick();
        end
        check("align_no_mw", seen_mw, 0);
        check("align_err_once", err_cnt, 1);
`else
        wait_mw(found);
        check("align_mw", found, 1);
        check("align_addr", MEM_ADDR2, 32'h1002);
        respond(1'b1);
        check("align_done", done, 1);
        check("align_tag", done_tag, 3);
`endif
        tick();

        // Reset in the middle of a request abandons the store
        drive_issue(32'h6000, 32'h0, 32'h66, 3'b010, 4'd2);
        tick();
        drive_idle();
        wait_mw(found);
        check("midrst_mw", found, 1);
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        check("midrst_mw_low", MEM_WRITE, 0);
        check("midrst_ready", ISSUE_READY, 1);
        check("midrst_done_tag", done_tag, 0);
        seen_mw = 1'b0; seen_err = 1'b0;
        for (int c = 0; c < 5; c++) begin
            seen_mw |= MEM_WRITE;
            seen_err |= done | err;
            tick();
        end
        check("midrst_quiet_mw", seen_mw, 0);
        check("midrst_quiet_resp", seen_err, 0);

        // Random issue and response traffic against a queue model
        exp_done = 1'b0; exp_err = 1'b0; exp_backoff = 1'b0; exp_tag = '0;
        nack_cnt = 0; stall = 0;
        for (int cyc = 0; cyc < 450; cyc++) begin
            check("rnd_ready", ISSUE_READY, mq.size() < DEPTH);
            check("rnd_done", done, exp_done);
            if (exp_done) check("rnd_tag", done_tag, exp_tag);
            check("rnd_err", err, exp_err);
            if (exp_backoff) check("rnd_backoff", MEM_WRITE, 0);
            if (mq.size() == 0) check("rnd_idle", MEM_WRITE, 0);
            if (MEM_WRITE && mq.size() > 0) begin
                h = mq[0];
                check("rnd_addr", MEM_ADDR2, h.addr);
                check("rnd_data", MEM_WRITE_DATA, h.data);
                check("rnd_size", MEM_SIZE, h.ty[1:0]);
                check("rnd_sign", MEM_SIGN, h.ty[2]);
            end
            if (mq.size() > 0 && !MEM_WRITE) stall++;
            else stall = 0;
            check("rnd_progress", stall > 3, 0);

            drive_idle();
            if (cyc < 350 && $urandom_range(0, 1) == 1) begin
                sz = 2'($urandom_range(0, 2));
                mask = (sz == 2'd0) ? 32'h0 : (sz == 2'd1) ? 32'h1 : 32'h3;
                addr = $urandom & ~mask;
                ISSUE_VALID = 1'b1;
                V1 = $urandom;
                V2 = addr - V1;
                V3 = $urandom;
                mem_type = {1'($urandom_range(0, 1)), sz};
                rd_tag = 4'($urandom);
                V1_valid = ($urandom_range(0, 7) != 0);
                V2_valid = ($urandom_range(0, 7) != 0);
                V3_valid = ($urandom_range(0, 7) != 0);
            end
            will_enq = ISSUE_VALID && V1_valid && V2_valid && V3_valid && (mq.size() < DEPTH);

            exp_done_n = 1'b0; exp_err_n = 1'b0; exp_backoff_n = 1'b0; exp_tag_n = exp_tag;
            mem_resp_valid = 1'b0; mem_resp = 1'b0;
            if (MEM_WRITE && mq.size() > 0) begin
                mem_resp_valid = ($urandom_range(0, 2) != 0);
                mem_resp = ($urandom_range(0, 3) != 0);
                if (mem_resp_valid) begin
                    if (mem_resp) begin
                        exp_done_n = 1'b1;
                        exp_tag_n = mq[0].tag;
                        void'(mq.pop_front());
                        nack_cnt = 0;
                    end else if (nack_cnt == MAX_RETRY) begin
                        exp_err_n = 1'b1;
                        void'(mq.pop_front());
                        nack_cnt = 0;
                    end else begin
                        nack_cnt++;
                        exp_backoff_n = 1'b1;
                    end
                end
            end
            if (will_enq) mq.push_back('{addr: V1 + V2, data: V3, ty: mem_type, tag: rd_tag});
            tick();
            exp_done = exp_done_n; exp_err = exp_err_n;
            exp_backoff = exp_backoff_n; exp_tag = exp_tag_n;
        end
        mem_resp_valid = 1'b0; mem_resp = 1'b0;
        drive_idle();
        check("rnd_drained", mq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
